// File: rtl/unary_multiplier_pkg.sv
// Shared definitions for the rate-coded unary multiplier datapath.
// Holds the default operand width and the counter bit-reversal helper.
package unary_multiplier_pkg;

    localparam int unsigned BITWIDTH_DEFAULT = 8;
    localparam int unsigned MAX_WIDTH = 32;

    // Reverses the low 'width' bits of value; bits above 'width' come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bitrev_n(
        input logic [MAX_WIDTH-1:0] value,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] rev;
        rev = {<<{value}};
        return rev >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/unary_multiplier_stream_gen.sv
// Converts an operand into a unary bitstream by comparing it against the shared
// window counter, optionally bit-reversed to decorrelate it from the other stream.
module unary_stream_gen
    import unary_multiplier_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT,
    parameter bit          REVERSE  = 1'b0
) (
    input  logic [BITWIDTH-1:0] cnt,
    input  logic [BITWIDTH-1:0] operand,
    output logic                stream_bit
);

    logic [BITWIDTH-1:0] cmp_val;

    generate
        if (REVERSE) begin : g_rev
            assign cmp_val = BITWIDTH'(bitrev_n(MAX_WIDTH'(cnt), BITWIDTH));
        end else begin : g_fwd
            assign cmp_val = cnt;
        end
    endgenerate

    assign stream_bit = (cmp_val < operand);

endmodule

// File: rtl/unary_multiplier.sv
// Rate-coded multiplier: ANDs two unary bitstreams and counts the ones over a
// 2^BITWIDTH-step window, giving roughly iData0 * iData1 / 2^BITWIDTH.
module unary_multiplier
    import unary_multiplier_pkg::*;
#(
    parameter int unsigned BITWIDTH = BITWIDTH_DEFAULT
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData0,
    input  logic [BITWIDTH-1:0] iData1,
    output logic [BITWIDTH:0]   oData,
    output logic                oDone
);

    localparam logic [BITWIDTH-1:0] CntLast = '1;

    logic [BITWIDTH-1:0] cnt_q, cnt_d;
    logic [BITWIDTH:0]   acc_q, acc_d;
    logic                done_q, done_d;
    logic                s0, s1, hit;

    unary_stream_gen #(
        .BITWIDTH (BITWIDTH),
        .REVERSE  (1'b0)
    ) u_stream0 (
        .cnt        (cnt_q),
        .operand    (iData0),
        .stream_bit (s0)
    );

    unary_stream_gen #(
        .BITWIDTH (BITWIDTH),
        .REVERSE  (1'b1)
    ) u_stream1 (
        .cnt        (cnt_q),
        .operand    (iData1),
        .stream_bit (s1)
    );

    assign hit = s0 & s1;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        done_d = done_q;
        if (iClr) begin
            cnt_d  = '0;
            acc_d  = '0;
            done_d = 1'b0;
        end else if (iEn && !done_q) begin
            acc_d = acc_q + {{BITWIDTH{1'b0}}, hit};
            cnt_d = cnt_q + 1'b1;
            // The edge that consumes the last counter value closes the window.
            if (cnt_q == CntLast) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            done_q <= done_d;
        end
    end

    assign oData = acc_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_unary_multiplier.sv
// Self-checking bench for unary_multiplier at BITWIDTH=8: table-driven windows
// plus hand-written enable-toggle, clear and reset sequences.
module tb_unary_multiplier;

    logic       clk = 1'b0;
    logic       iRst, iEn, iClr;
    logic [7:0] iData0, iData1;
    logic [8:0] oData;
    logic       oDone;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_q[$];

    typedef struct {
        logic [7:0]  d0;
        logic [7:0]  d1;
        int unsigned exp;
    } vec_t;

    vec_t vecs[7];

    unary_multiplier #(
        .BITWIDTH (8)
    ) dut (
        .iClk   (clk),
        .iRst   (iRst),
        .iEn    (iEn),
        .iClr   (iClr),
        .iData0 (iData0),
        .iData1 (iData1),
        .oData  (oData),
        .oDone  (oDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // Ones counted after n enabled steps from a cleared window.
    function automatic int unsigned model(input logic [7:0] a, input logic [7:0] b,
                                          input int unsigned n);
        int unsigned s = 0;
        for (int unsigned c = 0; c < n; c++) begin
            if ((c < 32'(a)) && (32'(rev8(8'(c))) < 32'(b))) s++;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_compare(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d, expected <empty scoreboard>", name, oData);
        end else begin
            check(name, 32'(oData), exp_q.pop_front());
        end
    endtask

    task automatic do_reset(input logic [7:0] a, input logic [7:0] b);
        iRst = 1'b1; iClr = 1'b0; iEn = 1'b0; iData0 = a; iData1 = b;
        tick();
        iRst = 1'b0;
    endtask

    task automatic run_window(input logic [7:0] a, input logic [7:0] b, input int unsigned e);
        do_reset(a, b);
        exp_q.push_back(e);
        iEn = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            tick();
            if (n == 255) check("done_early", 32'(oDone), 0);
        end
        check("done_at_256", 32'(oDone), 1);
        pop_compare("product");
        repeat (3) tick();
        check("hold_data", 32'(oData), e);
        check("hold_done", 32'(oDone), 1);
        iEn = 1'b0;
    endtask

    initial begin
        int unsigned en_edges, cyc;

        vecs[0] = '{d0: 8'd10,  d1: 8'd20,  exp: 2};
        vecs[1] = '{d0: 8'd128, d1: 8'd128, exp: 64};
        vecs[2] = '{d0: 8'd255, d1: 8'd20,  exp: 20};
        vecs[3] = '{d0: 8'd255, d1: 8'd255, exp: 255};
        vecs[4] = '{d0: 8'd0,   d1: 8'd200, exp: 0};
        vecs[5] = '{d0: 8'd37,  d1: 8'd91,  exp: model(8'd37, 8'd91, 256)};
        vecs[6] = '{d0: 8'd200, d1: 8'd3,   exp: model(8'd200, 8'd3, 256)};

        do_reset(8'd0, 8'd0);
        check("reset_data", 32'(oData), 0);
        check("reset_done", 32'(oDone), 0);

        foreach (vecs[i]) run_window(vecs[i].d0, vecs[i].d1, vecs[i].exp);

        // Enable toggled every cycle: the window spans 256 enabled edges only.
        do_reset(8'd10, 8'd20);
        exp_q.push_back(2);
        en_edges = 0;
        cyc = 0;
        while (en_edges < 256 && cyc < 600) begin
            iEn = (cyc % 2 == 0);
            tick();
            if (iEn) en_edges++;
            if (iEn && en_edges == 255) check("toggle_not_done", 32'(oDone), 0);
            if (!iEn) check("toggle_frozen", 32'(oData), model(8'd10, 8'd20, en_edges));
            cyc++;
        end
        check("toggle_edges", en_edges, 256);
        check("toggle_done", 32'(oDone), 1);
        pop_compare("toggle_product");

        // Clear mid-window, then a full restart.
        do_reset(8'd255, 8'd255);
        iEn = 1'b1;
        repeat (100) tick();
        check("partial_100", 32'(oData), model(8'd255, 8'd255, 100));
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        check("clr_data", 32'(oData), 0);
        check("clr_done", 32'(oDone), 0);
        exp_q.push_back(model(8'd255, 8'd255, 256));
        repeat (255) tick();
        check("restart_not_done", 32'(oDone), 0);
        tick();
        check("restart_done", 32'(oDone), 1);
        pop_compare("restart_product");

        // Clear after completion.
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        check("clr_after_done_data", 32'(oData), 0);
        check("clr_after_done_done", 32'(oDone), 0);

        // Enable low freezes a partial sum.
        repeat (30) tick();
        iEn = 1'b0;
        repeat (10) tick();
        check("freeze_data", 32'(oData), model(8'd255, 8'd255, 30));

        // Reset mid-window.
        iEn = 1'b1;
        repeat (50) tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("rst_mid_data", 32'(oData), 0);
        check("rst_mid_done", 32'(oDone), 0);

        // Reset and clear together behave as reset.
        repeat (20) tick();
        iRst = 1'b1;
        iClr = 1'b1;
        tick();
        iRst = 1'b0;
        iClr = 1'b0;
        check("rst_clr_data", 32'(oData), 0);
        check("rst_clr_done", 32'(oDone), 0);
        tick();
        check("rst_clr_step", 32'(oData), model(8'd255, 8'd255, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
